// File: rtl/wide_add_sequencer.sv
// Multi-precision add sequencer. Two requesters share one 16-bit adder that
// has no carry-in. Each wide add runs least-significant word first, and an
// incoming carry is absorbed by a second adder pass that adds 16'h0001.
module wide_add_sequencer #(
  parameter int WORDS = 4,
  localparam int DW = 16 * WORDS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_sum,
  output logic          rsp_cout,
  output logic          busy
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    INC  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t        state_r, state_n_s;
  logic [DW-1:0] a_r, b_r, result_r, result_n_s;
  logic [IW-1:0] idx_r;
  logic          carry_r, carry_n_s, c1_r, id_r, ptr_r;
  logic [15:0]   tmp_r;
  logic [15:0]   add_a_s, add_b_s, add_sum_s;
  logic          add_cout_s;
  logic          grant0_s, grant1_s, last_s;
  logic          rsp_valid_r, rsp_id_r, rsp_cout_r;
  logic [DW-1:0] rsp_sum_r;

  modifiedcarry_adder u_adder (
    .a    (add_a_s),
    .b    (add_b_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Arbitration: a lone valid wins; on a tie the priority pointer decides.
  always_comb begin
    grant0_s = req0_valid & (~req1_valid | ~ptr_r);
    grant1_s = req1_valid & (~req0_valid | ptr_r);
  end

  assign req0_ready = (state_r == IDLE) & grant0_s;
  assign req1_ready = (state_r == IDLE) & grant1_s;
  assign busy       = (state_r != IDLE);
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_sum    = rsp_sum_r;
  assign rsp_cout   = rsp_cout_r;
  assign last_s     = (idx_r == IW'(WORDS - 1));

  // Adder operand mux: current word pair in ADD, carry absorption in INC.
  always_comb begin
    add_a_s = 16'h0000;
    add_b_s = 16'h0000;
    case (state_r)
      ADD: begin
        add_a_s = a_r[{idx_r, 4'b0000} +: 16];
        add_b_s = b_r[{idx_r, 4'b0000} +: 16];
      end
      INC: begin
        add_a_s = tmp_r;
        add_b_s = 16'h0001;
      end
      default: begin
        add_a_s = 16'h0000;
        add_b_s = 16'h0000;
      end
    endcase
  end

  // Result with the current word replaced, and the carry leaving this word.
  always_comb begin
    result_n_s = result_r;
    result_n_s[{idx_r, 4'b0000} +: 16] = add_sum_s;
    if (state_r == INC) begin
      carry_n_s = c1_r | add_cout_s;
    end else begin
      carry_n_s = add_cout_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant0_s | grant1_s) state_n_s = ADD;
        else                     state_n_s = IDLE;
      end
      ADD: begin
        if (carry_r)     state_n_s = INC;
        else if (last_s) state_n_s = RESP;
        else             state_n_s = ADD;
      end
      INC: begin
        if (last_s) state_n_s = RESP;
        else        state_n_s = ADD;
      end
      RESP: begin
        if (rsp_ready) state_n_s = IDLE;
        else           state_n_s = RESP;
      end
      default: state_n_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_n_s;
  end

  // Datapath: operand capture, word sequencing and the registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r         <= '0;
      b_r         <= '0;
      result_r    <= '0;
      idx_r       <= '0;
      carry_r     <= 1'b0;
      c1_r        <= 1'b0;
      tmp_r       <= 16'h0000;
      id_r        <= 1'b0;
      ptr_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_sum_r   <= '0;
      rsp_cout_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant0_s | grant1_s) begin
            a_r     <= grant1_s ? req1_a : req0_a;
            b_r     <= grant1_s ? req1_b : req0_b;
            id_r    <= grant1_s;
            idx_r   <= '0;
            carry_r <= 1'b0;
          end
        end
        ADD, INC: begin
          if ((state_r == ADD) && carry_r) begin
            // Park the raw sum; the INC pass folds the carry in.
            tmp_r <= add_sum_s;
            c1_r  <= add_cout_s;
          end else begin
            result_r <= result_n_s;
            carry_r  <= carry_n_s;
            if (last_s) begin
              rsp_sum_r   <= result_n_s;
              rsp_cout_r  <= carry_n_s;
              rsp_id_r    <= id_r;
              rsp_valid_r <= 1'b1;
            end else begin
              idx_r <= idx_r + IW'(1);
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            ptr_r       <= ~rsp_id_r;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// Shared 16-bit adder without carry-in.
module modifiedcarry_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: directed scenarios followed by
// randomized operations, compared against an arithmetic reference model.
module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int DW    = 16 * WORDS;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [DW-1:0] rsp_sum;

  int compared   = 0;
  int mismatched = 0;

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide addition.
  function automatic logic [DW:0] ref_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Reference: number of words 1..WORDS-1 that receive a carry from below.
  function automatic int ref_k(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int k = 0;
    for (int i = 1; i < WORDS; i++) begin
      logic [DW:0] mask;
      logic [DW:0] s;
      mask = ((DW+1)'(1) << (16 * i)) - (DW+1)'(1);
      s = ({1'b0, a} & mask) + ({1'b0, b} & mask);
      if (s[16 * i]) k++;
    end
    return k;
  endfunction

  // Random operand; mode 1 biases words toward all-ones to provoke carries.
  function automatic logic [DW-1:0] rand_op(input int mode);
    logic [DW-1:0] v;
    for (int w = 0; w < WORDS; w++) begin
      if (mode == 1 && $urandom_range(0, 2) != 0) v[16*w +: 16] = 16'hFFFF;
      else                                        v[16*w +: 16] = 16'($urandom);
    end
    return v;
  endfunction

  task automatic drive(input int id, input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (id == 0) begin
      req0_valid = v; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b;
    end
  endtask

  function automatic logic ready_of(input int id);
    return (id == 0) ? req0_ready : req1_ready;
  endfunction

  // Called at a negedge with the request presented; returns at the negedge
  // following the accepting edge.
  task automatic accept(input int id);
    int n = 0;
    #1;
    while (ready_of(id) !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk($sformatf("ready%0d", id), 128'(ready_of(id)), 128'(1));
    chk("ready_onehot", 128'(req0_ready & req1_ready), 128'(0));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at the negedge after the accepting edge; checks latency, result,
  // optional backpressure hold, and the return to IDLE.
  task automatic collect(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b, input int stall);
    logic [DW:0] es;
    int          ek, n;
    logic        leak, unstable;
    es = ref_sum(a, b);
    ek = ref_k(a, b);
    rsp_ready = (stall == 0);
    chk("busy_in_op", 128'(busy), 128'(1));
    n = 0; leak = 1'b0; unstable = 1'b0;
    while (rsp_valid !== 1'b1 && n < 4 * WORDS) begin
      leak |= req0_ready | req1_ready;
      @(posedge clk); n++;
      @(negedge clk);
    end
    // Edges after the accepting edge: WORDS+K, i.e. WORDS+K+1 counting it.
    chk("latency", 128'(n), 128'(WORDS + ek));
    chk("rsp_sum", 128'(rsp_sum), 128'(es[DW-1:0]));
    chk("rsp_cout", 128'(rsp_cout), 128'(es[DW]));
    chk("rsp_id", 128'(rsp_id), 128'(id));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      leak |= req0_ready | req1_ready;
      if (rsp_valid !== 1'b1 || rsp_sum !== es[DW-1:0] || rsp_cout !== es[DW] ||
          rsp_id !== 1'(id) || busy !== 1'b1) unstable = 1'b1;
    end
    chk("hold_stable", 128'(unstable), 128'(0));
    chk("no_ready_in_op", 128'(leak), 128'(0));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rsp_drop", 128'(rsp_valid), 128'(0));
    chk("idle_after", 128'(busy), 128'(0));
    chk("sum_kept", 128'(rsp_sum), 128'(es[DW-1:0]));
  endtask

  initial begin
    logic [DW-1:0] x0, y0, x1, y1, x2, y2, ones, one;
    logic          seen;
    int            id, mode, stall;
    logic [DW-1:0] ra, rb;

    ones = '1;
    one  = DW'(1);
    rst = 1'b1; rsp_ready = 1'b1;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_sum", 128'(rsp_sum), 128'(0));
    chk("rst_rsp_cout", 128'(rsp_cout), 128'(0));
    chk("rst_rsp_id", 128'(rsp_id), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_readys", 128'({req0_ready, req1_ready}), 128'(0));

    // Contention: both requesters valid; expect req0, req1, req0.
    @(negedge clk);
    x0 = 64'h1111_2222_3333_4444; y0 = 64'h0101_0202_0303_0404;
    x1 = 64'h8000_7FFF_FFFF_0001; y1 = 64'h0000_0000_0001_FFFF;
    x2 = 64'hDEAD_BEEF_0000_FFFF; y2 = 64'h0000_0000_FFFF_0001;
    drive(0, 1'b1, x0, y0);
    drive(1, 1'b1, x1, y1);
    accept(0);
    drive(0, 1'b1, x2, y2);
    collect(0, x0, y0, 0);
    accept(1);
    drive(1, 1'b0, '0, '0);
    collect(1, x1, y1, 0);
    accept(0);
    drive(0, 1'b0, '0, '0);
    collect(0, x2, y2, 0);

    // Basic add, no carries.
    drive(0, 1'b1, one, one);
    accept(0);
    drive(0, 1'b0, '0, '0);
    collect(0, one, one, 0);

    // Full carry ripple through every word.
    drive(1, 1'b1, ones, one);
    accept(1);
    drive(1, 1'b0, '0, '0);
    collect(1, ones, one, 0);

    // Doubling all ones.
    drive(1, 1'b1, ones, ones);
    accept(1);
    drive(1, 1'b0, '0, '0);
    collect(1, ones, ones, 0);

    // Backpressure for ten cycles; leaves the pointer favouring req1.
    drive(0, 1'b1, 64'h00F0_00F0_00F0_00F0, 64'h00F0_00F0_00F0_00F0);
    accept(0);
    drive(0, 1'b0, '0, '0);
    collect(0, 64'h00F0_00F0_00F0_00F0, 64'h00F0_00F0_00F0_00F0, 10);
    chk("bp_value", 128'(rsp_sum), 128'(64'h01E0_01E0_01E0_01E0));

    // Reset while the ripple add sits in INC for word 1.
    drive(1, 1'b1, ones, one);
    accept(1);
    drive(1, 1'b0, '0, '0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("mid_rst_rsp_sum", 128'(rsp_sum), 128'(0));
    chk("mid_rst_rsp_cout", 128'(rsp_cout), 128'(0));
    chk("mid_rst_rsp_id", 128'(rsp_id), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    chk("no_rsp_after_rst", 128'(seen), 128'(0));

    // After reset the pointer favours req0 again.
    drive(0, 1'b1, x1, y1);
    drive(1, 1'b1, x2, y2);
    accept(0);
    drive(0, 1'b0, '0, '0);
    collect(0, x1, y1, 0);
    accept(1);
    drive(1, 1'b0, '0, '0);
    collect(1, x2, y2, 0);

    // Randomized single-requester operations.
    for (int t = 0; t < 24; t++) begin
      id    = int'($urandom_range(0, 1));
      mode  = int'($urandom_range(0, 1));
      stall = int'($urandom_range(0, 3));
      ra    = rand_op(mode);
      rb    = rand_op(mode);
      drive(id, 1'b1, ra, rb);
      accept(id);
      drive(id, 1'b0, '0, '0);
      collect(id, ra, rb, stall);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-precision add controller that time-shares one 16-bit `modifiedcarry_adder` instance (ports `a`, `b`, `sum`, `cout`; no carry-in) between two requesters.
- Each request is a 16*WORDS-bit add. The block sequences it word by word, least-significant word first.
- Because the adder has no carry-in, an incoming carry is absorbed by a second adder pass that adds 16'h0001.
- Sits between the two operand-producing clients and the shared adder; returns a registered wide sum plus carry-out.

Parameters:
- WORDS, 4, number of 16-bit words per operand (≥2); operand width DW = 16*WORDS.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 handshake accepted this cycle
- req0_a  in  DW  requester 0 operand A
- req0_b  in  DW  requester 0 operand B
- req1_valid  in  1  requester 1 has an operation pending
- req1_ready  out  1  requester 1 handshake accepted this cycle
- req1_a  in  DW  requester 1 operand A
- req1_b  in  DW  requester 1 operand B
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that issued the result
- rsp_sum  out  DW  A+B modulo 2^DW
- rsp_cout  out  1  carry out of bit DW-1
- busy  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, ADD, INC, RESP. Reset state is IDLE.
- Reset values: rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, priority pointer=0, word index=0, carry=0.
- Reset asserted mid-operation abandons the operation; no response is ever produced for it.
- Arbitration (IDLE only):
  - Grant is combinational from the two valids and the pointer.
  - One valid: grant that requester.
  - Both valid: grant the requester named by the pointer.
  - reqN_ready = (state==IDLE) & grantN. At most one ready is high at a time; both are low outside IDLE.
- Handshake: valid&ready at a rising edge does the following:
  - captures a, b and id;
  - sets idx=0, carry=0;
  - moves to ADD.
- Requesters hold valid/data stable until their handshake. Dropping valid before the handshake is legal and withdraws the request.
- ADD: adder a = A[idx], b = B[idx].
  - carry==0: result[idx]=sum, carry=cout, then advance.
  - carry==1: tmp=sum, c1=cout, go to INC.
- INC: adder a = tmp, b = 16'h0001. result[idx]=sum, carry=c1|cout, then advance. c1 and cout are never both 1.
- Advance:
  - idx==WORDS-1: rsp_sum=result, rsp_cout=carry, rsp_valid=1, go to RESP.
  - otherwise: idx+1, go to ADD.
- Word 0 never takes INC.
- Latency from the handshake edge to rsp_valid high is WORDS + K + 1 edges later. K = number of words 1..WORDS-1 with carry-in 1. Range is WORDS+1 to 2*WORDS.
- RESP:
  - rsp_valid, rsp_sum, rsp_cout and rsp_id are held stable until rsp_valid&rsp_ready.
  - On that edge: rsp_valid=0, pointer = ~rsp_id, go to IDLE.
  - rsp_sum, rsp_cout and rsp_id keep their last values after the response.
- A new request cannot be accepted in the same cycle as a response handshake. Minimum spacing is one IDLE cycle.
- Adder inputs are don't-care in IDLE and RESP; drive them to 0.

Test Plan:
1. Basic add: req0 a=0x0000_0000_0000_0001, b=0x0000_0000_0000_0001, rsp_ready=1 → handshake, rsp_valid 5 edges later; rsp_sum=0x0000_0000_0000_0002, rsp_cout=0, rsp_id=0; no INC visited.
2. Full carry ripple: req1 a=0xFFFF_FFFF_FFFF_FFFF, b=0x0000_0000_0000_0001 → 3 INC passes, rsp_valid 8 edges after handshake; rsp_sum=0, rsp_cout=1, rsp_id=1.
3. Doubling all ones: a=b=0xFFFF_FFFF_FFFF_FFFF → rsp_sum=0xFFFF_FFFF_FFFF_FFFE, rsp_cout=1, latency 8 edges.
4. Contention: both valids held from reset with distinct operands → req0 served first, then req1, then req0. The ready pulses alternate and exactly one ready is high per IDLE cycle.
5. Backpressure: rsp_ready=0 for 10 cycles after rsp_valid (a=b=0x00F0_00F0_00F0_00F0) → outputs stable at rsp_sum=0x01E0_01E0_01E0_01E0; both readys stay low; IDLE is entered only after rsp_ready rises.
6. Reset mid-op: assert rst during INC of scenario 2 → all outputs go to reset values immediately; no rsp_valid afterwards; the next request completes normally with pointer=0 priority.
